// File: rtl/pd_drive_pkg.sv
// pd_drive_pkg: shared state encoding, default widths and saturation limit for pd_drive_ctrl.
package pd_drive_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, MUL_P, MUL_D, SUM, SAT} state_t;
  localparam int PD_IN_W   = 16;
  localparam int PD_OUT_W  = 10;
  localparam int PD_GAIN_W = 8;
  localparam int PD_FRAC   = 4;
  function automatic int sat_lim(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
endpackage

// File: rtl/pd_drive_ctrl_seq_mult.sv
// seq_mult: signed multiplicand x unsigned multiplier, shift-add, one multiplier bit per cycle.
module seq_mult #(
  parameter int MW = 18,
  parameter int NW = 8
) (
  input  logic                 clk,
  input  logic                 synch_reset_n,
  input  logic                 start,
  input  logic signed [MW-1:0] mcand,
  input  logic [NW-1:0]        mplier,
  output logic                 running,
  output logic                 done,
  output logic signed [MW+NW-1:0] result
);
  localparam int RW = MW + NW;
  localparam int CW = $clog2(NW + 1);
  logic signed [RW-1:0] ext, sh;
  logic [NW-1:0] mp;
  logic [CW-1:0] cnt;
  assign ext  = {{NW{mcand[MW-1]}}, mcand};
  // start consumes bit 0, so done flags the cycle whose edge retires the last bit
  assign done = running && cnt == 1;
  always_ff @(posedge clk) begin
    if (!synch_reset_n) begin
      running <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      sh      <= '0;
      mp      <= '0;
    end else if (start) begin
      result  <= mplier[0] ? ext : '0;
      sh      <= ext << 1;
      mp      <= mplier >> 1;
      cnt     <= CW'(NW - 1);
      running <= 1'b1;
    end else if (running) begin
      result  <= result + (mp[0] ? sh : '0);
      sh      <= sh << 1;
      mp      <= mp >> 1;
      cnt     <= cnt - 1'b1;
      running <= cnt != 1;
    end
  end
endmodule

// File: rtl/pd_drive_ctrl.sv
// pd_drive_ctrl: sampled PD controller producing a saturated symmetric duty word for pwm.
// Derivative path (MUL_D, derr, err_prev) is built only when PD_DRIVE_DERIV_EN is defined.
module pd_drive_ctrl
  import pd_drive_pkg::*;
#(
  parameter int IN_W   = PD_IN_W,
  parameter int OUT_W  = PD_OUT_W,
  parameter int GAIN_W = PD_GAIN_W,
  parameter int FRAC   = PD_FRAC
) (
  input  logic                    clk,
  input  logic                    synch_reset_n,
  input  logic                    enable,
  input  logic                    sample,
  input  logic signed [IN_W-1:0]  setpoint,
  input  logic signed [IN_W-1:0]  position,
  input  logic [GAIN_W-1:0]       kp,
  input  logic [GAIN_W-1:0]       kd,
  output logic signed [OUT_W-1:0] drive,
  output logic                    drive_valid,
  output logic                    busy,
  output logic                    sat,
  output logic                    overrun
);
  localparam int MW = IN_W + 2;
  localparam int RW = MW + GAIN_W;
  localparam int SW = IN_W + GAIN_W + 3;
  localparam logic signed [SW-1:0] LIM  = SW'(sat_lim(OUT_W));
  localparam logic signed [SW-1:0] NLIM = -LIM;
  state_t state;
  logic signed [IN_W:0] err, err_new;
  logic signed [MW-1:0] mcand;
  logic [GAIN_W-1:0] mplier;
  logic signed [RW-1:0] result;
  logic signed [SW-1:0] sum, acc;
  logic start, done, mul_run, hi, lo;
  assign err_new = {setpoint[IN_W-1], setpoint} - {position[IN_W-1], position};
  assign start   = (state == MUL_P || state == MUL_D) && !mul_run;
  assign hi      = acc > LIM;
  assign lo      = acc < NLIM;
`ifdef PD_DRIVE_DERIV_EN
  localparam state_t AFTER_P = MUL_D;
  logic signed [IN_W:0] err_prev;
  logic signed [MW-1:0] derr;
  logic signed [RW-1:0] prod_p;
  assign mcand  = state == MUL_D ? derr : {err[IN_W], err};
  assign mplier = state == MUL_D ? kd : kp;
  assign sum    = {prod_p[RW-1], prod_p} + {result[RW-1], result};
  always_ff @(posedge clk) begin
    if (!synch_reset_n || !enable) begin
      err_prev <= '0;
      derr     <= '0;
      prod_p   <= '0;
    end else if (state == LATCH) begin
      err_prev <= err_new;
      derr     <= {err_new[IN_W], err_new} - {err_prev[IN_W], err_prev};
    end else if (state == MUL_D && start) begin
      prod_p   <= result;
    end
  end
`else
  localparam state_t AFTER_P = SUM;
  logic unused_kd;
  assign unused_kd = ^kd;
  assign mcand     = {err[IN_W], err};
  assign mplier    = kp;
  assign sum       = {result[RW-1], result};
`endif
  seq_mult #(.MW(MW), .NW(GAIN_W)) u_mult (
    .clk(clk),
    .synch_reset_n(synch_reset_n & enable),
    .start(start),
    .mcand(mcand),
    .mplier(mplier),
    .running(mul_run),
    .done(done),
    .result(result)
  );
  always_ff @(posedge clk) begin
    if (!synch_reset_n) begin
      state       <= IDLE;
      drive       <= '0;
      drive_valid <= 1'b0;
      busy        <= 1'b0;
      sat         <= 1'b0;
      overrun     <= 1'b0;
      err         <= '0;
      acc         <= '0;
    end else begin
      drive_valid <= 1'b0;
      if (sample && enable && busy) overrun <= 1'b1;
      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
        drive <= '0;
        sat   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (sample) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
          LATCH: begin
            err   <= err_new;
            state <= MUL_P;
          end
          MUL_P: if (done) state <= AFTER_P;
          MUL_D: if (done) state <= SUM;
          SUM: begin
            acc   <= sum >>> FRAC;
            state <= SAT;
          end
          SAT: begin
            drive       <= hi ? LIM[OUT_W-1:0] : lo ? NLIM[OUT_W-1:0] : acc[OUT_W-1:0];
            sat         <= hi || lo;
            drive_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pd_drive_ctrl.sv
// tb_pd_drive_ctrl: directed self-checking bench for pd_drive_ctrl (expectations follow PD_DRIVE_DERIV_EN).
module tb_pd_drive_ctrl;
  logic clk = 1'b0, synch_reset_n = 1'b0, enable = 1'b0, sample = 1'b0;
  logic signed [15:0] setpoint = '0, position = '0;
  logic [7:0] kp = '0, kd = '0;
  logic signed [9:0] drive;
  logic drive_valid, busy, sat, overrun;
  int n_cmp = 0, n_bad = 0;
`ifdef PD_DRIVE_DERIV_EN
  localparam int L = 19;
  localparam bit DERIV = 1'b1;
`else
  localparam int L = 11;
  localparam bit DERIV = 1'b0;
`endif
  always #5 clk = ~clk;

  pd_drive_ctrl dut (
    .clk(clk), .synch_reset_n(synch_reset_n), .enable(enable), .sample(sample),
    .setpoint(setpoint), .position(position), .kp(kp), .kd(kd),
    .drive(drive), .drive_valid(drive_valid), .busy(busy), .sat(sat), .overrun(overrun)
  );

  task automatic set_in(input int sp, input int pos, input int p, input int d);
    setpoint = 16'(sp); position = 16'(pos); kp = 8'(p); kd = 8'(d);
  endtask

  task automatic fire(output int lat, output logic b0);
    @(negedge clk); sample = 1'b1;
    @(posedge clk); #1 sample = 1'b0; b0 = busy;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (drive_valid) lat = k;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (drive !== 10'sd0) begin n_bad++; $display("FAIL reset_drive got %0d want 0", drive); end
    n_cmp++; if (drive_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", drive_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", sat); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    @(negedge clk); synch_reset_n = 1'b1; enable = 1'b1;
  endtask

  task automatic test_prop;
    int lat; logic b0;
    set_in(100, 0, 16, 0);
    fire(lat, b0);
    n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL prop_busy_rise got %b want 1", b0); end
    n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL prop_latency got %0d want %0d", lat, L); end
    n_cmp++; if (drive !== 10'sd100) begin n_bad++; $display("FAIL prop_drive got %0d want 100", drive); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL prop_sat got %b want 0", sat); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL prop_busy_fall got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (drive_valid !== 1'b0) begin n_bad++; $display("FAIL prop_valid_pulse got %b want 0", drive_valid); end
    n_cmp++; if (drive !== 10'sd100) begin n_bad++; $display("FAIL prop_hold got %0d want 100", drive); end
  endtask

  task automatic test_sat;
    int lat; logic b0;
    set_in(0, 1000, 16, 0);
    fire(lat, b0);
    n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL sat_latency got %0d want %0d", lat, L); end
    n_cmp++; if (drive !== -10'sd511) begin n_bad++; $display("FAIL sat_drive got %0d want -511", drive); end
    n_cmp++; if (sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag got %b want 1", sat); end
  endtask

  task automatic test_enable;
    bit seen;
    set_in(100, 0, 16, 0);
    @(negedge clk); sample = 1'b1;
    @(posedge clk); #1 sample = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (drive !== 10'sd0) begin n_bad++; $display("FAIL en_drive got %0d want 0", drive); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL en_sat got %b want 0", sat); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_busy got %b want 0", busy); end
    @(negedge clk); sample = 1'b1;
    @(posedge clk); #1 sample = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_sample_ignored got %b want 0", busy); end
    seen = 1'b0;
    repeat (L + 2) begin @(posedge clk); #1; if (drive_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL en_no_valid got %b want 0", seen); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL en_overrun got %b want 0", overrun); end
    @(negedge clk); enable = 1'b1;
  endtask

  task automatic test_deriv;
    int lat; logic b0;
    set_in(10, 0, 0, 32);
    fire(lat, b0);
    n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL deriv1_latency got %0d want %0d", lat, L); end
    n_cmp++; if (drive !== (DERIV ? 10'sd20 : 10'sd0)) begin n_bad++; $display("FAIL deriv1_drive got %0d want %0d", drive, DERIV ? 20 : 0); end
    fire(lat, b0);
    n_cmp++; if (drive !== 10'sd0) begin n_bad++; $display("FAIL deriv2_drive got %0d want 0", drive); end
  endtask

  task automatic test_floor;
    int lat; logic b0;
    set_in(5, 0, 3, 0);
    fire(lat, b0);
    n_cmp++; if (drive !== 10'sd0) begin n_bad++; $display("FAIL floor_pos got %0d want 0", drive); end
    set_in(-5, 0, 3, 0);
    fire(lat, b0);
    n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL floor_latency got %0d want %0d", lat, L); end
    n_cmp++; if (drive !== -10'sd1) begin n_bad++; $display("FAIL floor_neg got %0d want -1", drive); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL back_to_back_overrun got %b want 0", overrun); end
  endtask

  task automatic test_overrun;
    int lat; logic b0;
    set_in(50, 0, 16, 0);
    @(negedge clk); sample = 1'b1;
    @(posedge clk); #1 sample = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); setpoint = 16'sd200; sample = 1'b1;
    @(posedge clk); #1 sample = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", overrun); end
    lat = -1;
    for (int k = 5; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (drive_valid) lat = k;
    end
    n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL ovr_latency got %0d want %0d", lat, L); end
    n_cmp++; if (drive !== 10'sd50) begin n_bad++; $display("FAIL ovr_drive got %0d want 50", drive); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovr_no_restart got %b want 0", busy); end
    set_in(60, 0, 16, 0);
    fire(lat, b0);
    n_cmp++; if (drive !== 10'sd60) begin n_bad++; $display("FAIL ovr_next_drive got %0d want 60", drive); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_reset_abort;
    int lat; logic b0; bit seen;
    set_in(30, 0, 16, 0);
    @(negedge clk); sample = 1'b1;
    @(posedge clk); #1 sample = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); synch_reset_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (drive !== 10'sd0) begin n_bad++; $display("FAIL abort_drive got %0d want 0", drive); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL abort_overrun got %b want 0", overrun); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL abort_sat got %b want 0", sat); end
    @(negedge clk); synch_reset_n = 1'b1;
    seen = 1'b0;
    repeat (L + 2) begin @(posedge clk); #1; if (drive_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_valid got %b want 0", seen); end
    set_in(10, 0, 16, 32);
    fire(lat, b0);
    n_cmp++; if (lat !== L) begin n_bad++; $display("FAIL abort_after_latency got %0d want %0d", lat, L); end
    n_cmp++; if (drive !== (DERIV ? 10'sd30 : 10'sd10)) begin n_bad++; $display("FAIL abort_after_drive got %0d want %0d", drive, DERIV ? 30 : 10); end
  endtask

  initial begin
    test_reset;
    test_prop;
    test_sat;
    test_enable;
    test_deriv;
    test_floor;
    test_overrun;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
